// File: rtl/bram_pkg.sv
// Shared types and constants for the simple-dual-port block RAM family.
// Latency: none (type definitions only).
// Backpressure: none.
package bram_pkg;

    typedef enum logic {READ_FIRST, WRITE_FIRST} rdw_mode_e;

    typedef enum logic {INIT, READY} bram_state_e;

    localparam int BYTE_W = 8;

endpackage

// File: rtl/bram_rd_pipe.sv
// {valid,data} delay line behind the RAM read register; STAGES=0 is a wire.
// Latency: STAGES cycles.
// Backpressure: none, one entry per cycle always advances.
module bram_rd_pipe #(
    parameter int DLEN   = 8,
    parameter int STAGES = 0
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            in_vld,
    input  logic [DLEN-1:0] in_dat,
    output logic            out_vld,
    output logic [DLEN-1:0] out_dat
);

    generate
        if (STAGES == 0) begin : g_pass
            logic unused_clk_rst;
            assign unused_clk_rst = clk & rstn;
            assign out_vld = in_vld;
            assign out_dat = in_dat;
        end else begin : g_pipe
            logic            vld_q [STAGES];
            logic [DLEN-1:0] dat_q [STAGES];

            // Data registers only move with a valid entry so idle cycles do not toggle them.
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    for (int i = 0; i < STAGES; i++) begin
                        vld_q[i] <= 1'b0;
                        dat_q[i] <= '0;
                    end
                end else begin
                    vld_q[0] <= in_vld;
                    if (in_vld) dat_q[0] <= in_dat;
                    for (int i = 1; i < STAGES; i++) begin
                        vld_q[i] <= vld_q[i-1];
                        if (vld_q[i-1]) dat_q[i] <= dat_q[i-1];
                    end
                end
            end

            assign out_vld = vld_q[STAGES-1];
            assign out_dat = dat_q[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/bram_sdp_pipe.sv
// Simple-dual-port RAM with byte enables, selectable read-during-write and post-reset clear sweep.
// Latency: read data and rvalid RD_LATENCY cycles after an accepted ren.
// Backpressure: none; accesses are ignored (not stalled) until init_done.
module bram_sdp_pipe
    import bram_pkg::*;
#(
    parameter int               ALEN           = 2,
    parameter int               DLEN           = 8,
    parameter int               RD_LATENCY     = 1,
    parameter rdw_mode_e        RDW_MODE       = WRITE_FIRST,
    parameter bit               CLEAR_ON_RESET = 1'b1,
    parameter logic [DLEN-1:0]  INIT_VALUE     = '0
) (
    input  logic                 clk,
    input  logic                 rstn,
    output logic                 init_done,
    input  logic                 wen,
    input  logic [DLEN/8-1:0]    wbe,
    input  logic [ALEN-1:0]      waddr,
    input  logic [DLEN-1:0]      wdata,
    input  logic                 ren,
    input  logic [ALEN-1:0]      raddr,
    output logic [DLEN-1:0]      rdata,
    output logic                 rvalid
);

    localparam int              DEPTH       = 2**ALEN;
    localparam int              NBYTES      = DLEN / BYTE_W;
    localparam int              PIPE_STAGES = (RD_LATENCY > 1) ? RD_LATENCY - 1 : 0;
    localparam logic [ALEN-1:0] LAST_ADDR   = ALEN'(DEPTH - 1);

    generate
        if ((DLEN % BYTE_W) != 0 || DLEN == 0) begin : g_bad_dlen
            $error("bram_sdp_pipe: DLEN must be a non-zero multiple of 8");
        end
        if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_latency
            $error("bram_sdp_pipe: RD_LATENCY must be in 1..4");
        end
    endgenerate

    logic [DLEN-1:0] mem [DEPTH];

    bram_state_e     state_q, state_d;
    logic [ALEN-1:0] clr_addr_q, clr_addr_d;
    logic            clr_we;
    logic            wr_acc, rd_acc;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= CLEAR_ON_RESET ? INIT : READY;
            clr_addr_q <= '0;
            init_done  <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            init_done  <= (state_q == READY);
        end
    end

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        clr_we     = 1'b0;
        case (state_q)
            INIT: begin
                clr_we = 1'b1;
                if (clr_addr_q == LAST_ADDR) state_d = READY;
                else                         clr_addr_d = clr_addr_q + ALEN'(1);
            end
            default: ;
        endcase
    end

    assign wr_acc = wen && init_done;
    assign rd_acc = ren && init_done;

    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr_q] <= INIT_VALUE;
        end else if (wr_acc) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (wbe[b]) mem[waddr][b*BYTE_W +: BYTE_W] <= wdata[b*BYTE_W +: BYTE_W];
            end
        end
    end

    // Write-first forwarding: the word as it will look after this edge's write.
    logic [DLEN-1:0] merged_word;
    logic [DLEN-1:0] rd_word;
    logic            fwd;

    always_comb begin
        merged_word = mem[raddr];
        for (int b = 0; b < NBYTES; b++) begin
            if (wbe[b]) merged_word[b*BYTE_W +: BYTE_W] = wdata[b*BYTE_W +: BYTE_W];
        end
    end

    assign fwd     = (RDW_MODE == WRITE_FIRST) && wr_acc && (waddr == raddr);
    assign rd_word = fwd ? merged_word : mem[raddr];

    logic            rd0_vld;
    logic [DLEN-1:0] rd0_dat;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd0_vld <= 1'b0;
            rd0_dat <= '0;
        end else begin
            rd0_vld <= rd_acc;
            if (rd_acc) rd0_dat <= rd_word;
        end
    end

    bram_rd_pipe #(
        .DLEN   (DLEN),
        .STAGES (PIPE_STAGES)
    ) u_rd_pipe (
        .clk     (clk),
        .rstn    (rstn),
        .in_vld  (rd0_vld),
        .in_dat  (rd0_dat),
        .out_vld (rvalid),
        .out_dat (rdata)
    );

endmodule

// File: tb/tb_bram_sdp_pipe.sv
// Directed bench: four clearing instances (latency 1..4, latency 2 is read-first) share one stimulus bus,
// plus a non-clearing instance for init_done timing.
module tb_bram_sdp_pipe;
    import bram_pkg::*;

    localparam int LAT [4] = '{1, 2, 3, 4};

    logic        clk = 1'b0;
    logic        rstn;
    logic        wen;
    logic [1:0]  wbe;
    logic [1:0]  waddr;
    logic [15:0] wdata;
    logic        ren;
    logic [1:0]  raddr;

    logic        init_done_a [4];
    logic        rvalid_a    [4];
    logic [15:0] rdata_a     [4];
    logic        nc_init_done, nc_rvalid;
    logic [15:0] nc_rdata;

    always #5 clk = ~clk;

    bram_sdp_pipe #(.ALEN(2), .DLEN(16), .RD_LATENCY(LAT[0]), .RDW_MODE(WRITE_FIRST),
                    .CLEAR_ON_RESET(1'b1), .INIT_VALUE(16'hA5A5)) u_l1 (
        .clk(clk), .rstn(rstn), .init_done(init_done_a[0]), .wen(wen), .wbe(wbe), .waddr(waddr),
        .wdata(wdata), .ren(ren), .raddr(raddr), .rdata(rdata_a[0]), .rvalid(rvalid_a[0]));
    bram_sdp_pipe #(.ALEN(2), .DLEN(16), .RD_LATENCY(LAT[1]), .RDW_MODE(READ_FIRST),
                    .CLEAR_ON_RESET(1'b1), .INIT_VALUE(16'hA5A5)) u_l2_rf (
        .clk(clk), .rstn(rstn), .init_done(init_done_a[1]), .wen(wen), .wbe(wbe), .waddr(waddr),
        .wdata(wdata), .ren(ren), .raddr(raddr), .rdata(rdata_a[1]), .rvalid(rvalid_a[1]));
    bram_sdp_pipe #(.ALEN(2), .DLEN(16), .RD_LATENCY(LAT[2]), .RDW_MODE(WRITE_FIRST),
                    .CLEAR_ON_RESET(1'b1), .INIT_VALUE(16'hA5A5)) u_l3 (
        .clk(clk), .rstn(rstn), .init_done(init_done_a[2]), .wen(wen), .wbe(wbe), .waddr(waddr),
        .wdata(wdata), .ren(ren), .raddr(raddr), .rdata(rdata_a[2]), .rvalid(rvalid_a[2]));
    bram_sdp_pipe #(.ALEN(2), .DLEN(16), .RD_LATENCY(LAT[3]), .RDW_MODE(WRITE_FIRST),
                    .CLEAR_ON_RESET(1'b1), .INIT_VALUE(16'hA5A5)) u_l4 (
        .clk(clk), .rstn(rstn), .init_done(init_done_a[3]), .wen(wen), .wbe(wbe), .waddr(waddr),
        .wdata(wdata), .ren(ren), .raddr(raddr), .rdata(rdata_a[3]), .rvalid(rvalid_a[3]));
    bram_sdp_pipe #(.ALEN(2), .DLEN(16), .RD_LATENCY(1), .RDW_MODE(WRITE_FIRST),
                    .CLEAR_ON_RESET(1'b0), .INIT_VALUE(16'h0000)) u_noclr (
        .clk(clk), .rstn(rstn), .init_done(nc_init_done), .wen(wen), .wbe(wbe), .waddr(waddr),
        .wdata(wdata), .ren(ren), .raddr(raddr), .rdata(nc_rdata), .rvalid(nc_rvalid));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Every rvalid pulse is logged with the cycle number it was seen in.
    int          cap_n   [4] = '{0, 0, 0, 0};
    int          cap_cyc [4][32];
    logic [15:0] cap_dat [4][32];
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (rvalid_a[i]) begin
                cap_cyc[i][cap_n[i] % 32] = cyc;
                cap_dat[i][cap_n[i] % 32] = rdata_a[i];
                cap_n[i] = cap_n[i] + 1;
            end
        end
    end

    int          checks = 0;
    int          errors = 0;
    int          mark  [4];
    logic [15:0] ex_wf [4];
    logic [15:0] ex_rf [4];

    typedef struct {
        logic        wen;
        logic [1:0]  wbe;
        logic [1:0]  waddr;
        logic [15:0] wdata;
        logic        ren;
        logic [1:0]  raddr;
        logic [15:0] exp_wf;
        logic [15:0] exp_rf;
    } vec_t;
    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic w, input logic [1:0] be, input logic [1:0] wa,
                         input logic [15:0] wd, input logic r, input logic [1:0] ra);
        wen = w; wbe = be; waddr = wa; wdata = wd; ren = r; raddr = ra;
    endtask

    task automatic idle();
        drive(1'b0, 2'b00, 2'd0, 16'h0000, 1'b0, 2'd0);
    endtask

    task automatic set_mark();
        for (int i = 0; i < 4; i++) mark[i] = cap_n[i];
    endtask

    // n reads issued on consecutive cycles starting at cycle `issue`; instance 1 is read-first.
    task automatic check_reads(input int issue, input int n);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rd_count_l%0d", LAT[i]), cap_n[i] - mark[i], n);
            for (int j = 0; j < n && j < cap_n[i] - mark[i]; j++) begin
                int k;
                k = (mark[i] + j) % 32;
                check($sformatf("rd_cyc_l%0d_%0d", LAT[i], j), cap_cyc[i][k], issue + LAT[i] + j);
                check($sformatf("rd_dat_l%0d_%0d", LAT[i], j), {16'h0, cap_dat[i][k]},
                      {16'h0, (i == 1) ? ex_rf[j] : ex_wf[j]});
            end
        end
    endtask

    task automatic read_seq();
        int issue;
        set_mark();
        issue = cyc;
        for (int a = 0; a < 4; a++) begin
            drive(1'b0, 2'b00, 2'd0, 16'h0000, 1'b1, 2'(a));
            step(1);
        end
        idle();
        step(6);
        check_reads(issue, 4);
    endtask

    task automatic expect_init_after_release(input string tag);
        for (int e = 1; e <= 5; e++) begin
            step(1);
            for (int i = 0; i < 4; i++)
                check($sformatf("%s_init_done_l%0d_e%0d", tag, LAT[i], e), init_done_a[i], (e >= 5));
        end
    endtask

    initial begin
        vecs[0] = '{1'b1, 2'b11, 2'd1, 16'h1234, 1'b0, 2'd0, 16'h0000, 16'h0000};
        vecs[1] = '{1'b1, 2'b10, 2'd1, 16'hFF00, 1'b0, 2'd0, 16'h0000, 16'h0000};
        vecs[2] = '{1'b0, 2'b00, 2'd0, 16'h0000, 1'b1, 2'd1, 16'hFF34, 16'hFF34};
        vecs[3] = '{1'b1, 2'b11, 2'd2, 16'h0011, 1'b0, 2'd0, 16'h0000, 16'h0000};
        vecs[4] = '{1'b1, 2'b01, 2'd2, 16'hEEEE, 1'b1, 2'd2, 16'h00EE, 16'h0011};
        vecs[5] = '{1'b0, 2'b00, 2'd0, 16'h0000, 1'b1, 2'd2, 16'h00EE, 16'h00EE};
        vecs[6] = '{1'b1, 2'b00, 2'd3, 16'h5678, 1'b1, 2'd3, 16'hA5A5, 16'hA5A5};
        vecs[7] = '{1'b1, 2'b01, 2'd0, 16'h00C3, 1'b1, 2'd3, 16'hA5A5, 16'hA5A5};
        vecs[8] = '{1'b0, 2'b00, 2'd0, 16'h0000, 1'b1, 2'd0, 16'hA5C3, 16'hA5C3};
        vecs[9] = '{1'b0, 2'b00, 2'd0, 16'h0000, 1'b1, 2'd3, 16'hA5A5, 16'hA5A5};

        rstn = 1'b1;
        idle();
        #3 rstn = 1'b0;
        step(3);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rst_init_done_l%0d", LAT[i]), init_done_a[i], 1'b0);
            check($sformatf("rst_rvalid_l%0d", LAT[i]), rvalid_a[i], 1'b0);
            check($sformatf("rst_rdata_l%0d", LAT[i]), rdata_a[i], 16'h0000);
        end
        check("rst_noclr_init_done", nc_init_done, 1'b0);
        check("rst_noclr_rvalid", nc_rvalid, 1'b0);
        check("rst_noclr_rdata", nc_rdata, 16'h0000);

        // Accesses held on the bus for the whole sweep must be ignored.
        set_mark();
        drive(1'b1, 2'b11, 2'd0, 16'hDEAD, 1'b1, 2'd0);
        rstn = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            step(1);
            for (int i = 0; i < 4; i++)
                check($sformatf("sweep_init_done_l%0d_e%0d", LAT[i], e), init_done_a[i], (e >= 5));
            check($sformatf("noclr_init_done_e%0d", e), nc_init_done, 1'b1);
        end
        idle();
        step(6);
        check_reads(0, 0);

        for (int j = 0; j < 4; j++) begin ex_wf[j] = 16'hA5A5; ex_rf[j] = 16'hA5A5; end
        read_seq();

        for (int v = 0; v < 10; v++) begin
            int issue;
            set_mark();
            issue = cyc;
            drive(vecs[v].wen, vecs[v].wbe, vecs[v].waddr, vecs[v].wdata, vecs[v].ren, vecs[v].raddr);
            step(1);
            idle();
            step(5);
            ex_wf[0] = vecs[v].exp_wf;
            ex_rf[0] = vecs[v].exp_rf;
            check_reads(issue, vecs[v].ren ? 1 : 0);
        end

        // Read on the edge right after a write sees the new data.
        begin
            int issue;
            set_mark();
            drive(1'b1, 2'b11, 2'd3, 16'hBEEF, 1'b0, 2'd0);
            step(1);
            issue = cyc;
            drive(1'b0, 2'b00, 2'd0, 16'h0000, 1'b1, 2'd3);
            step(1);
            idle();
            step(6);
            ex_wf[0] = 16'hBEEF;
            ex_rf[0] = 16'hBEEF;
            check_reads(issue, 1);
        end

        ex_wf[0] = 16'hA5C3; ex_wf[1] = 16'hFF34; ex_wf[2] = 16'h00EE; ex_wf[3] = 16'hBEEF;
        ex_rf = ex_wf;
        read_seq();

        // Reset with reads in flight, then reset again partway through the sweep.
        set_mark();
        drive(1'b0, 2'b00, 2'd0, 16'h0000, 1'b1, 2'd0);
        step(1);
        rstn = 1'b0;
        idle();
        #1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("inflight_rvalid_l%0d", LAT[i]), rvalid_a[i], 1'b0);
            check($sformatf("inflight_rdata_l%0d", LAT[i]), rdata_a[i], 16'h0000);
        end
        step(2);
        check_reads(0, 0);
        for (int i = 0; i < 4; i++)
            check($sformatf("inflight_init_done_l%0d", LAT[i]), init_done_a[i], 1'b0);
        rstn = 1'b1;
        step(2);
        rstn = 1'b0;
        step(1);
        rstn = 1'b1;
        expect_init_after_release("resweep");

        for (int j = 0; j < 4; j++) begin ex_wf[j] = 16'hA5A5; ex_rf[j] = 16'hA5A5; end
        read_seq();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
